// File: rtl/serial_addsub.sv
// Multi-cycle add/subtract unit: WIDTH-bit operands are processed DIGIT bits per
// clock, LSB first, through a single DIGIT-bit adder slice.
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   start           request, accepted in IDLE or DONE
//   a, b, ci, sub   operands, carry/borrow-in, mode (sampled on accepted start)
//   busy            high while the operation is running
//   done            one-cycle pulse when sum/cout/ovf are updated
//   sum, cout, ovf  result, raw carry out of MSB, two's-complement overflow
module serial_addsub #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DIGIT = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   input  logic             sub,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned CYCLES = WIDTH / DIGIT;
   localparam int unsigned CW     = $clog2(CYCLES) + 1;

   if (DIGIT == 0 || WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_param_check
      $error("serial_addsub: WIDTH must be >= 2 and an integer multiple of DIGIT");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic [CW-1:0]    cnt_q;

   logic [DIGIT:0]   slice_c;
   logic             msb_cin_c;
   logic [WIDTH-1:0] res_next_c;
   logic             last_c;

   // One DIGIT-bit slice: {carry_out, sum_bits}
   assign slice_c = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(carry_q);

   // Carry into the slice MSB, recovered from the MSB sum bit
   assign msb_cin_c = slice_c[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];

   // Slice result enters from the MSB side so the final word ends up LSB-aligned
   assign res_next_c = WIDTH'({slice_c[DIGIT-1:0], res_q} >> DIGIT);

   assign last_c = (cnt_q == CW'(CYCLES - 1));

   // Control FSM and datapath registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         busy    <= 1'b0;
         done    <= 1'b0;
         sum     <= '0;
         cout    <= 1'b0;
         ovf     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE, S_DONE: begin
               if (start) begin
                  // Subtract as a + ~b + ~borrow
                  a_q     <= a;
                  b_q     <= sub ? ~b : b;
                  carry_q <= sub ? ~ci : ci;
                  res_q   <= '0;
                  cnt_q   <= '0;
                  busy    <= 1'b1;
                  state   <= S_RUN;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               res_q   <= res_next_c;
               carry_q <= slice_c[DIGIT];
               cnt_q   <= cnt_q + CW'(1);
               if (last_c) begin
                  sum   <= res_next_c;
                  cout  <= slice_c[DIGIT];
                  ovf   <= slice_c[DIGIT] ^ msb_cin_c;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= S_DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
